// File: rtl/gpu_pkg.sv
// gpu_pkg: shared state encoding and default sizing for the kernel dispatcher.
package gpu_pkg;
    typedef enum logic [1:0] {IDLE, RESET_CORES, DISPATCH, DONE} dispatch_state_t;
    localparam int DEF_THREADS_PER_BLOCK = 4;
    localparam int DEF_NUM_CORES = 2;
endpackage

// File: rtl/dispatch_if.sv
// dispatch_if: launch request, core handshake and status signals of the dispatcher.
interface dispatch_if
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK,
    parameter int DATA_WIDTH = 8
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
    logic                          start;
    logic [DATA_WIDTH-1:0]         thread_count;
    logic [NUM_CORES-1:0]          core_done;
    logic [NUM_CORES-1:0]          core_start;
    logic [NUM_CORES-1:0]          core_reset;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_block_id;
    logic [NUM_CORES*TCW-1:0]      core_thread_count;
    logic                          busy;
    logic                          done;
    modport master (
        output start, thread_count, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count, busy, done
    );
    modport slave (
        input  start, thread_count, core_done,
        output core_start, core_reset, core_block_id, core_thread_count, busy, done
    );
endinterface

// File: rtl/dispatch_priority_pick.sv
// priority_pick: lowest-index set-bit encoder with a valid flag.
module priority_pick #(
    parameter int N = 2,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? IW'(i) : idx_o;
    end
endmodule

// File: rtl/dispatch.sv
// dispatch: splits a kernel launch into fixed-size thread blocks and hands them to
// compute cores one at a time, recycling each core as it retires its block.
module dispatch
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK,
    parameter int DATA_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    dispatch_if.slave bus
);
    localparam int SH = $clog2(THREADS_PER_BLOCK);
    localparam int TCW = SH + 1;
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'(THREADS_PER_BLOCK - 1);
    localparam logic [DATA_WIDTH-1:0] TPB = DATA_WIDTH'(THREADS_PER_BLOCK);

    dispatch_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] tc_q, tc_d, total_q, total_d, disp_q, disp_d, retired_q, retired_d;
    logic [NUM_CORES-1:0] cs_q, cs_d, cr_q, cr_d;
    logic [NUM_CORES-1:0][DATA_WIDTH-1:0] id_q, id_d;
    logic [NUM_CORES-1:0][TCW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [NUM_CORES-1:0] free, comp;
    logic [DATA_WIDTH-1:0] rem, ncomp;
    logic pick_v;
    logic [IW-1:0] pick_idx;

    assign free = ~cs_q & ~cr_q;
    assign comp = bus.core_done & cs_q;
    assign rem  = tc_q - (disp_q << SH);

    priority_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
        .req_i  (free),
        .valid_o(pick_v),
        .idx_o  (pick_idx)
    );

    always_comb begin
        ncomp = '0;
        for (int i = 0; i < NUM_CORES; i++) ncomp = ncomp + DATA_WIDTH'(comp[i]);
    end

    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        total_d   = total_q;
        disp_d    = disp_q;
        retired_d = retired_q;
        cs_d      = cs_q;
        cr_d      = '0;
        id_d      = id_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                tc_d      = bus.thread_count;
                total_d   = (bus.thread_count >> SH)
                          + {{(DATA_WIDTH-1){1'b0}}, |(bus.thread_count & MASK)};
                disp_d    = '0;
                retired_d = '0;
                cs_d      = '0;
                cr_d      = '1;
                state_d   = RESET_CORES;
            end
            RESET_CORES: state_d = (total_q == '0) ? DONE : DISPATCH;
            DISPATCH: begin
                cs_d      = cs_q & ~comp;
                cr_d      = comp;
                retired_d = retired_q + ncomp;
                // A core completing this cycle is not free; it sits out one reset cycle first.
                if (pick_v && disp_q < total_q) begin
                    cs_d[pick_idx]  = 1'b1;
                    id_d[pick_idx]  = disp_q;
                    cnt_d[pick_idx] = (rem >= TPB) ? TCW'(THREADS_PER_BLOCK) : rem[TCW-1:0];
                    disp_d          = disp_q + 1'b1;
                end
                if (retired_d == total_q) state_d = DONE;
            end
        endcase
        busy_d = (state_d == RESET_CORES) || (state_d == DISPATCH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tc_q      <= '0;
            total_q   <= '0;
            disp_q    <= '0;
            retired_q <= '0;
            cs_q      <= '0;
            cr_q      <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            total_q   <= total_d;
            disp_q    <= disp_d;
            retired_q <= retired_d;
            cs_q      <= cs_d;
            cr_q      <= cr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.core_start        = cs_q;
    assign bus.core_reset        = cr_q;
    assign bus.core_block_id     = id_q;
    assign bus.core_thread_count = cnt_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: scoreboard bench; expected dispatches are queued at launch and
// popped as each core_start rises.
module tb_dispatch;
    import gpu_pkg::*;
    localparam int NC = 2;
    localparam int TPB = 4;
    localparam int DW = 8;
    localparam int TCW = $clog2(TPB) + 1;

    typedef struct {int core; int id; int cnt;} disp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    disp_t exp_q[$];
    logic [NC-1:0] prev_cs = '0;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dispatch_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .DATA_WIDTH(DW)) bus ();

    dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int core, input int id, input int tc);
        disp_t e;
        e.core = core;
        e.id   = id;
        e.cnt  = (tc - id * TPB) < TPB ? tc - id * TPB : TPB;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        disp_t e;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (bus.core_start[i] && !prev_cs[i]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dispatch", i, 99);
                end else begin
                    e = exp_q.pop_front();
                    check("disp_core", i, e.core);
                    check("disp_id", bus.core_block_id[i*DW +: DW], e.id);
                    check("disp_cnt", bus.core_thread_count[i*TCW +: TCW], e.cnt);
                end
            end
        end
        prev_cs = bus.core_start;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"}, bus.core_start, 0);
        check({tag, "_cr"}, bus.core_reset, 0);
        check({tag, "_id"}, bus.core_block_id, 0);
        check({tag, "_cnt"}, bus.core_thread_count, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
    endtask

    task automatic launch(input int tc);
        bus.start = 1'b1;
        bus.thread_count = DW'(tc);
        tick();
        bus.start = 1'b0;
        check("launch_busy", bus.busy, 1);
        check("launch_done", bus.done, 0);
        check("launch_cr", bus.core_reset, 2'b11);
        tick();
        check("launch_cr_clear", bus.core_reset, 0);
    endtask

    task automatic pulse_done(input logic [NC-1:0] d);
        bus.core_done = d;
        tick();
        bus.core_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.thread_count = '0;
        bus.core_done = '0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        tick();
        check_idle("idle");

        // Even split: 8 threads -> two full blocks
        push(0, 0, 8);
        push(1, 1, 8);
        launch(8);
        tick();
        tick();
        check("even_cs", bus.core_start, 2'b11);
        pulse_done(2'b11);
        check("even_done", bus.done, 1);
        check("even_busy", bus.busy, 0);
        check("even_cr", bus.core_reset, 2'b11);
        check("even_cs_clr", bus.core_start, 0);
        tick();
        check("even_cr_clr", bus.core_reset, 0);
        check("even_done_hold", bus.done, 1);
        check("even_sb", exp_q.size(), 0);

        // Partial last block, with ignored start/thread_count and spurious done
        push(0, 0, 10);
        push(1, 1, 10);
        launch(10);
        tick();
        tick();
        check("part_cs", bus.core_start, 2'b11);
        push(1, 2, 10);
        bus.start = 1'b1;
        bus.thread_count = 8'd200;
        pulse_done(2'b10);
        bus.start = 1'b0;
        check("part_cs_rec", bus.core_start, 2'b01);
        check("part_cr_rec", bus.core_reset, 2'b10);
        tick();
        check("part_cr_clr", bus.core_reset, 0);
        tick();
        check("part_cs_redisp", bus.core_start, 2'b11);
        pulse_done(2'b01);
        pulse_done(2'b01);
        pulse_done(2'b01);
        check("part_spur_done", bus.done, 0);
        check("part_spur_busy", bus.busy, 1);
        check("part_spur_cs", bus.core_start, 2'b10);
        pulse_done(2'b10);
        check("part_done", bus.done, 1);
        check("part_busy", bus.busy, 0);
        check("part_sb", exp_q.size(), 0);

        // Zero threads
        launch(0);
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        tick();
        check("zero_cs", bus.core_start, 0);
        check("zero_done_hold", bus.done, 1);

        // Simultaneous completion
        push(0, 0, 16);
        push(1, 1, 16);
        launch(16);
        tick();
        tick();
        check("sim_cs", bus.core_start, 2'b11);
        push(0, 2, 16);
        push(1, 3, 16);
        pulse_done(2'b11);
        check("sim_cs_clr", bus.core_start, 0);
        check("sim_cr", bus.core_reset, 2'b11);
        check("sim_busy", bus.busy, 1);
        tick();
        check("sim_cr_clr", bus.core_reset, 0);
        tick();
        check("sim_cs0", bus.core_start, 2'b01);
        tick();
        check("sim_cs1", bus.core_start, 2'b11);
        pulse_done(2'b11);
        check("sim_done", bus.done, 1);
        check("sim_sb", exp_q.size(), 0);

        // Reset mid-kernel, then a fresh launch
        push(0, 0, 12);
        push(1, 1, 12);
        launch(12);
        tick();
        tick();
        check("mid_cs", bus.core_start, 2'b11);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 4);
        launch(4);
        tick();
        check("fresh_cs", bus.core_start, 2'b01);
        pulse_done(2'b01);
        check("fresh_done", bus.done, 1);
        check("fresh_sb", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
